// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch alignment buffer and its halfword queue.
package fetch_pkg;
   localparam logic [1:0] OPC_32BIT     = 2'b11;
   localparam int         HW_DEPTH_DFLT = 4;
   localparam int         HW_DEPTH_MAX  = 8;

   typedef logic [15:0] hw_t;
   // sized for the largest legal depth so one type serves both configurations
   typedef logic [$clog2(HW_DEPTH_MAX):0] cnt_t;
endpackage

// File: rtl/halfword_queue.sv
// Circular halfword queue: 0/1/2 push and 0/1/2 pop per cycle, synchronous flush.
// Head halfwords and count come straight from registers; the caller never overflows or underflows it.
module halfword_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = HW_DEPTH_DFLT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush_i,
   input  logic [1:0] push_n_i,
   input  hw_t        push_lo_i,
   input  hw_t        push_hi_i,
   input  logic [1:0] pop_n_i,
   output hw_t        head0_o,
   output hw_t        head1_o,
   output cnt_t       count_o
);
   localparam int PW = $clog2(DEPTH);

   hw_t           hw_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] head_p1, tail_p1;
   cnt_t          count_q, count_d;

   assign head_p1 = head_q + PW'(1);
   assign tail_p1 = tail_q + PW'(1);

   always_comb begin
      head_d  = head_q + PW'(pop_n_i);
      tail_d  = tail_q + PW'(push_n_i);
      count_d = count_q + cnt_t'(push_n_i) - cnt_t'(pop_n_i);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush_i && push_n_i != 2'd0) hw_q[tail_q]  <= push_lo_i;
      if (!flush_i && push_n_i == 2'd2) hw_q[tail_p1] <= push_hi_i;
   end

   assign head0_o = hw_q[head_q];
   assign head1_o = hw_q[head_p1];
   assign count_o = count_q;
endmodule

// File: rtl/fetch_align_buffer.sv
// Splits word-aligned fetch data into RV32IC instructions with PCs; define RVC_EN for compressed support.
// A word returned in cycle N is visible in N+1; one fetch in flight, inst_ready stalls, redirect flushes.
module fetch_align_buffer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          HW_DEPTH = HW_DEPTH_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_is_c
);
   hw_t         h0, h1, push_lo;
   cnt_t        count;
   logic        is_c, fire, skip_lo, unused_ok;
   logic [1:0]  push_n, pop_n;
   logic [31:0] fetch_addr_q, head_pc_q;
   logic        outstanding_q, drop_q;

`ifdef RVC_EN
   logic skip_lo_q;
   assign skip_lo = skip_lo_q;
   assign is_c    = (h0[1:0] != OPC_32BIT);
`else
   assign skip_lo = 1'b0;
   assign is_c    = 1'b0;
`endif

   assign unused_ok = ^redirect_pc[1:0];

   // at least two free slots so a whole word always fits when it returns
   assign mem_req  = !rst && !outstanding_q && !redirect_valid &&
                     (count <= cnt_t'(HW_DEPTH - 2));
   assign mem_addr = fetch_addr_q;

   assign inst_valid = is_c ? (count >= cnt_t'(1)) : (count >= cnt_t'(2));
   assign inst       = !inst_valid ? 32'h0 : (is_c ? {16'h0, h0} : {h1, h0});
   assign inst_pc    = head_pc_q;
   assign inst_is_c  = inst_valid && is_c;

   assign fire    = inst_valid && inst_ready && !redirect_valid;
   assign pop_n   = !fire ? 2'd0 : (is_c ? 2'd1 : 2'd2);
   assign push_n  = (redirect_valid || !mem_valid || drop_q) ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
   assign push_lo = skip_lo ? mem_rdata[31:16] : mem_rdata[15:0];

   halfword_queue #(.DEPTH(HW_DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (redirect_valid),
      .push_n_i  (push_n),
      .push_lo_i (push_lo),
      .push_hi_i (mem_rdata[31:16]),
      .pop_n_i   (pop_n),
      .head0_o   (h0),
      .head1_o   (h1),
      .count_o   (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_addr_q  <= RESET_PC;
         head_pc_q     <= RESET_PC;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
      end else if (redirect_valid) begin
         // a response landing in this same cycle is simply not pushed
         fetch_addr_q  <= {redirect_pc[31:2], 2'b00};
         outstanding_q <= outstanding_q && !mem_valid;
         drop_q        <= outstanding_q && !mem_valid;
`ifdef RVC_EN
         head_pc_q     <= {redirect_pc[31:1], 1'b0};
`else
         head_pc_q     <= {redirect_pc[31:2], 2'b00};
`endif
      end else begin
         if (mem_req) begin
            outstanding_q <= 1'b1;
            fetch_addr_q  <= fetch_addr_q + 32'd4;
         end
         if (mem_valid) begin
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
         end
         if (fire) head_pc_q <= head_pc_q + (is_c ? 32'd2 : 32'd4);
      end
   end

`ifdef RVC_EN
   always_ff @(posedge clk) begin
      if (rst)                       skip_lo_q <= 1'b0;
      else if (redirect_valid)       skip_lo_q <= redirect_pc[1];
      else if (mem_valid && !drop_q) skip_lo_q <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: behavioural memory, ISA-level expected stream, directed and random phases.
module tb_fetch_align_buffer;
`ifdef RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   logic        clk, rst, redirect_valid, mem_req, mem_valid, inst_valid, inst_ready, inst_is_c;
   logic [31:0] redirect_pc, mem_addr, mem_rdata, inst, inst_pc;

   fetch_align_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_valid      (mem_valid),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_is_c      (inst_is_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, lat = 1, ready_lvl = 1, nacc = 0, probe_hits = 0, due = 0;
   logic        rst_req = 1'b1, pend = 1'b0, probe_armed = 1'b0, probe_next = 1'b0, held;
   logic [31:0] pend_addr = 32'h0, dlv_addr = 32'h0, probe_addr = 32'h0, h_inst, h_pc;
   logic [31:0] img [256];
   logic [31:0] req_log [$];
   exp_t        sb [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = img[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // expected instruction stream, decoded at ISA level from the memory image
   task automatic model_fill(input logic [31:0] rpc);
      logic [31:0] pc;
      logic [15:0] h;
      exp_t        e;
      sb.delete();
      pc = RVC ? {rpc[31:1], 1'b0} : {rpc[31:2], 2'b00};
      for (int i = 0; i < 200; i++) begin
         h    = hw_at(pc);
         e.pc = pc;
         if (RVC && h[1:0] != 2'b11) begin
            e.inst = {16'h0, h};
            e.c    = 1'b1;
            pc     = pc + 32'd2;
         end else begin
            e.inst = {hw_at(pc + 32'd2), h};
            e.c    = 1'b0;
            pc     = pc + 32'd4;
         end
         sb.push_back(e);
      end
   endtask

   task automatic step(input logic redir, input logic [31:0] rpc);
      logic busy;
      exp_t e;
      @(negedge clk);
      cyc++;
      rst       = rst_req;
      busy      = pend;
      mem_valid = 1'b0;
      mem_rdata = 32'h0;
      if (rst) pend = 1'b0;
      else if (pend && due == cyc) begin
         mem_valid = 1'b1;
         mem_rdata = img[pend_addr[9:2]];
         dlv_addr  = pend_addr;
         pend      = 1'b0;
      end
      redirect_valid = redir;
      redirect_pc    = rpc;
      case (ready_lvl)
         0:       inst_ready = 1'b0;
         1:       inst_ready = 1'b1;
         default: inst_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (!rst) begin
         if (probe_next) begin
            chk("lat_vld", 32'(inst_valid), 32'd1);
            chk("lat_pc", inst_pc, sb.size() > 0 ? sb[0].pc : 32'hFFFF_FFFF);
            probe_next = 1'b0;
         end
         if (mem_valid && !redir && probe_armed && dlv_addr == probe_addr) begin
            chk("lat_pre", 32'(inst_valid), 32'd0);
            probe_armed = 1'b0;
            probe_next  = 1'b1;
            probe_hits++;
         end
         if (redir) chk("req_in_redir", 32'(mem_req), 32'd0);
         if (mem_req) begin
            chk("one_outst", 32'(busy), 32'd0);
            chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
            req_log.push_back(mem_addr);
            pend      = 1'b1;
            pend_addr = mem_addr;
            due       = cyc + lat;
         end
         if (inst_valid && inst_ready && !redir) begin
            if (sb.size() == 0) chk("extra_inst", 32'(sb.size()), 32'd1);
            else begin
               e = sb.pop_front();
               chk("inst", inst, e.inst);
               chk("inst_pc", inst_pc, e.pc);
               chk("inst_is_c", 32'(inst_is_c), 32'(e.c));
            end
            nacc++;
         end
         if (redir) begin
            model_fill(rpc);
            probe_next = 1'b0;
         end
      end
   endtask

   task automatic run_acc(input int n, input int budget, input string tag);
      int tgt;
      tgt = nacc + n;
      for (int i = 0; i < budget && nacc < tgt; i++) step(1'b0, 32'h0);
      chk(tag, 32'(nacc >= tgt), 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      mem_valid = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b0;
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      img[0] = 32'h0001_4501;
      img[8] = 32'h0513_0001;
      img[9] = 32'h0000_0050;

      // reset values
      repeat (3) step(1'b0, 32'h0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_vld", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_is_c", 32'(inst_is_c), 32'd0);

      // first fetch straight after reset, word 0 splits into two instructions
      model_fill(32'h0);
      probe_armed = 1'b1; probe_addr = 32'h0;
      rst_req = 1'b0;
      step(1'b0, 32'h0);
      chk("first_req", 32'(mem_req), 32'd1);
      chk("first_addr", mem_addr, 32'h0);
      run_acc(2, 20, "t1_acc");
      chk("req2_addr", req_log.size() >= 2 ? req_log[1] : 32'hFFFF_FFFF, 32'h4);

      // instruction straddling a word boundary
      lat = 3;
      step(1'b1, 32'h20);
      probe_armed = 1'b1; probe_addr = 32'h24;
      run_acc(4, 60, "t2_acc");
      chk("t2_probe", 32'(probe_hits), 32'd2);

      // redirect to a halfword target while a request is outstanding
      for (int i = 0; i < 20 && !(pend && due > cyc + 1); i++) step(1'b0, 32'h0);
      step(1'b1, 32'h102);
      n = req_log.size();
      for (int i = 0; i < 20 && req_log.size() <= n; i++) step(1'b0, 32'h0);
      chk("t3_addr", req_log.size() > n ? req_log[n] : 32'hFFFF_FFFF, 32'h100);
      run_acc(6, 60, "t3_acc");

      // downstream stall for 10 cycles
      lat = 1;
      run_acc(1, 20, "t4_pre");
      ready_lvl = 0; held = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'h0);
         if (held) begin
            chk("stall_vld", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, h_inst);
            chk("stall_pc", inst_pc, h_pc);
         end else if (inst_valid) begin
            held = 1'b1; h_inst = inst; h_pc = inst_pc;
         end
      end
      chk("t4_held", 32'(held), 32'd1);
      chk("t4_req_off", 32'(mem_req), 32'd0);
      ready_lvl = 1;
      run_acc(8, 60, "t4_acc");

      // redirect in the same cycle as a response
      lat = 2;
      for (int i = 0; i < 20 && !(pend && due == cyc + 1); i++) step(1'b0, 32'h0);
      step(1'b1, 32'h40);
      step(1'b0, 32'h0);
      chk("same_vld", 32'(inst_valid), 32'd0);
      chk("same_req", 32'(mem_req), 32'd1);
      chk("same_addr", mem_addr, 32'h40);
      run_acc(6, 60, "t5_acc");

      // random redirects, latencies and ready patterns
      for (int p = 0; p < 8; p++) begin
         lat = int'($urandom_range(1, 3));
         ready_lvl = 2;
         step(1'b1, $urandom & 32'h3FF);
         repeat (40) step(1'b0, 32'h0);
      end
      ready_lvl = 1;
      run_acc(3, 40, "final_acc");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
